fetch_redirect_ctrl: RTL and testbench
======================================

// Module: fetch_redirect_ctrl
// PURPOSE
//   Scheduler between the jump/branch resolution logic and the fetch stage. Arbitrates taken-branch
//   and JAL/JALR redirect requests, holds the chosen target until fetch accepts it, then flushes
//   in-flight wrong-path instructions for a fixed number of cycles. Tracks pending rd writes
//   (scoreboard) to stall a JALR whose rs is not yet written back.
// PARAMETERS
//   XLEN          32          datapath / PC width
//   FLUSH_CYCLES  2           cycles flush stays high after fetch accepts a redirect (>=1)
//   SB_DEPTH      2           scoreboard entries, i.e. number of issued-but-unwritten rd tracked
//   TRAP_VEC      32'h0000_0010  misaligned-target trap vector (MISALIGN_TRAP_EN only)
// PORTS
//   clock           in   1     single clock, all state on posedge
//   reset           in   1     synchronous, active-high
//   br_req          in   1     taken branch resolved this cycle (oldest instruction in flight)
//   br_target       in   XLEN  branch target
//   jal_req         in   1     JAL/JALR resolved in decode this cycle
//   jal_is_jalr     in   1     1 = JALR (rs hazard check applies)
//   jal_rs          in   5     JALR source register
//   jal_target      in   XLEN  JAL/JALR target
//   issue_valid     in   1     instruction issued from decode this cycle
//   issue_rd        in   5     its destination register (0 = none)
//   fetch_ready     in   1     fetch accepts redirect_pc this cycle
//   redirect_valid  out  1     redirect_pc valid, held until fetch_ready
//   redirect_pc     out  XLEN  new fetch PC
//   flush           out  1     squash fetch/decode contents
//   stall_dec       out  1     hold decode (combinational)
//   jal_grant       out  1     jal_req accepted this cycle (combinational)
//   busy            out  1     state != IDLE
//   misalign_trap   out  1     one-cycle pulse, trap redirect taken (0 without macro)
// BEHAVIOUR
//   Reset: state IDLE, redirect_valid=0, redirect_pc=0, flush=0, busy=0, misalign_trap=0,
//     all scoreboard entries 0. Reset in any state abandons the redirect at once.
//   FSM: IDLE -> REDIRECT on accepted request; REDIRECT -> FLUSH when fetch_ready=1
//     (-> IDLE directly if FLUSH_CYCLES==1); FLUSH counts FLUSH_CYCLES-1 down to 0 -> IDLE.
//   Outputs registered: request accepted in cycle N => redirect_valid=1, flush=1, busy=1 in N+1.
//     flush stays 1 through REDIRECT and FLUSH; redirect_valid=0 in FLUSH.
//   Arbitration: br_req beats jal_req in the same cycle (JAL is younger, on squashed path):
//     jal_grant=0. br_req in REDIRECT or FLUSH overrides: new target latched, state REDIRECT,
//     counter reloaded. jal_req while busy is ignored (jal_grant=0).
//   JALR hazard: jal_is_jalr && jal_rs!=0 && jal_rs equals any scoreboard entry =>
//     stall_dec=1, jal_grant=0; decode re-presents jal_req until clear. stall_dec also =1 while busy.
//   Scoreboard: SB_DEPTH-deep shift register; each cycle shifts in (issue_valid && !flush &&
//     !stall_dec) ? issue_rd : 0, so a hazard clears within SB_DEPTH cycles. Not cleared on flush
//     (conservative). x0 never matches.
//   redirect_pc: target with bits [1:0] forced to 0.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: accepted target with target[1:0]!=0 redirects to TRAP_VEC instead
//     and misalign_trap pulses for one cycle together with the first redirect_valid cycle.
//   Not defined: bits [1:0] silently cleared, misalign_trap tied 0, TRAP_VEC unused.
// TESTING
//   jal_req=1 target 0x100, fetch_ready=1 -> N+1 redirect_valid=1 pc=0x100 flush=1; flush low
//     after FLUSH_CYCLES more cycles; busy low afterwards.
//   br_req target 0x200 and jal_req target 0x300 same cycle -> jal_grant=0, redirect_pc=0x200.
//   jal_req accepted, fetch_ready=0 for 3 cycles, br_req 0x400 in cycle 2 -> pc switches to 0x400,
//     held until fetch_ready, flush continuous.
//   issue rd=5, next cycle JALR rs=5 -> stall_dec=1, jal_grant=0 for SB_DEPTH cycles, then granted;
//     JALR rs=0 with rd=0 pending -> no stall.
//   reset asserted in REDIRECT -> next cycle all outputs 0, state IDLE, scoreboard clear.
//   MISALIGN_TRAP_EN: target 0x102 -> redirect_pc=TRAP_VEC, misalign_trap 1 cycle; without: 0x100.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect request/response bundle between resolve, decode and fetch
interface fetch_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  logic            br_req;
  logic [XLEN-1:0] br_target;
  logic            jal_req;
  logic            jal_is_jalr;
  logic [4:0]      jal_rs;
  logic [XLEN-1:0] jal_target;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            fetch_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            stall_dec;
  logic            jal_grant;
  logic            busy;
  logic            misalign_trap;

  modport master (
    output br_req, br_target, jal_req, jal_is_jalr, jal_rs, jal_target,
           issue_valid, issue_rd, fetch_ready,
    input  redirect_valid, redirect_pc, flush, stall_dec, jal_grant, busy, misalign_trap
  );

  modport slave (
    input  br_req, br_target, jal_req, jal_is_jalr, jal_rs, jal_target,
           issue_valid, issue_rd, fetch_ready,
    output redirect_valid, redirect_pc, flush, stall_dec, jal_grant, busy, misalign_trap
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - branch/JAL redirect arbiter, flush sequencer and JALR rs scoreboard
// Optional: define MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VEC.
module fetch_redirect_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              SB_DEPTH     = 2,
  parameter logic [XLEN-1:0] TRAP_VEC     = 32'h0000_0010
) (
  input logic                  clock,
  input logic                  reset,
  fetch_redirect_ctrl_if.slave bus
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [4:0]      sb [SB_DEPTH];
  logic [4:0]      sb_in;
  logic            rs_hit, hazard, busy, accept;
  logic [XLEN-1:0] sel_target;

  always_comb begin
    rs_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb[i] == bus.jal_rs) rs_hit = 1'b1;
    end
  end

  assign busy       = (state != S_IDLE);
  assign hazard     = bus.jal_req && bus.jal_is_jalr && (bus.jal_rs != 5'd0) && rs_hit;
  assign accept     = bus.br_req || bus.jal_grant;
  assign sel_target = bus.br_req ? bus.br_target : bus.jal_target;

  assign bus.busy           = busy;
  assign bus.flush          = busy;
  assign bus.redirect_valid = (state == S_REDIRECT);
  assign bus.redirect_pc    = pc;
  assign bus.stall_dec      = busy || hazard;
  assign bus.jal_grant      = bus.jal_req && !bus.br_req && !busy && !hazard;

  // Stalled or squashed issues shift in x0 so a stale rd ages out within SB_DEPTH cycles.
  assign sb_in = (bus.issue_valid && !bus.flush && !bus.stall_dec) ? bus.issue_rd : 5'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= 5'd0;
    end else begin
      sb[0] <= sb_in;
      for (int i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_next;
  assign trap_next = accept && (sel_target[1:0] != 2'b00);
  always_ff @(posedge clock) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= trap_next;
  end
  assign bus.misalign_trap = trap_q;
`else
  logic unused_bits;
  assign unused_bits       = ^{TRAP_VEC, sel_target[1:0]};
  assign bus.misalign_trap = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pc    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pc    <= pc_next;
    end
  end

  // A branch always wins, even mid-redirect or mid-flush: it is the oldest instruction.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pc_next    = pc;
    if (accept) begin
      state_next = S_REDIRECT;
      cnt_next   = CNT_LOAD;
`ifdef MISALIGN_TRAP_EN
      if (sel_target[1:0] != 2'b00) pc_next = {TRAP_VEC[XLEN-1:2], 2'b00};
      else                          pc_next = {sel_target[XLEN-1:2], 2'b00};
`else
      pc_next = {sel_target[XLEN-1:2], 2'b00};
`endif
    end else begin
      case (state)
        S_REDIRECT: begin
          if (bus.fetch_ready) begin
            state_next = (FLUSH_CYCLES == 1) ? S_IDLE : S_FLUSH;
            cnt_next   = CNT_LOAD;
          end
        end
        S_FLUSH: begin
          if (cnt == '0) state_next = S_IDLE;
          else           cnt_next   = cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed and randomized check of fetch_redirect_ctrl against a behavioural model
module tb_fetch_redirect_ctrl;
  localparam int          XLEN         = 32;
  localparam int          FLUSH_CYCLES = 2;
  localparam int          SB_DEPTH     = 2;
  localparam logic [31:0] TRAP_VEC     = 32'h0000_0010;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

  fetch_redirect_ctrl #(
    .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .SB_DEPTH(SB_DEPTH), .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: pending redirect flag, its PC, flush cycles left after fetch took it, recent rd history.
  bit          m_pend;
  logic [31:0] m_pc;
  int          m_left;
  bit          m_trap;
  int          m_sb[$];

  logic        e_busy, e_stall, e_grant;
  logic        s_grant, s_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_pc   = 32'h0;
    m_left = 0;
    m_trap = 1'b0;
    m_sb   = {};
    for (int i = 0; i < SB_DEPTH; i++) m_sb.push_back(0);
  endtask

  task automatic predict();
    bit hit;
    hit = 1'b0;
    foreach (m_sb[i]) if (m_sb[i] == int'(bus.jal_rs)) hit = 1'b1;
    e_busy  = m_pend || (m_left > 0);
    e_stall = e_busy || (bus.jal_req && bus.jal_is_jalr && bus.jal_rs != 5'd0 && hit);
    e_grant = bus.jal_req && !bus.br_req && !e_stall;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    int sin;
    if (reset) begin
      model_reset();
      return;
    end
    sin = (bus.issue_valid && !e_busy && !e_stall) ? int'(bus.issue_rd) : 0;
    m_sb.push_front(sin);
    void'(m_sb.pop_back());
    m_trap = 1'b0;
    if (bus.br_req || e_grant) begin
      tgt    = bus.br_req ? bus.br_target : bus.jal_target;
      m_pend = 1'b1;
      m_left = 0;
      m_pc   = tgt & ~32'h3;
`ifdef MISALIGN_TRAP_EN
      if (tgt % 4 != 0) begin
        m_pc   = TRAP_VEC;
        m_trap = 1'b1;
      end
`endif
    end else if (m_pend) begin
      if (bus.fetch_ready) begin
        m_pend = 1'b0;
        m_left = (FLUSH_CYCLES == 1) ? 0 : FLUSH_CYCLES;
      end
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    predict();
    s_grant = bus.jal_grant;
    s_stall = bus.stall_dec;
    chk("busy", bus.busy, e_busy);
    chk("flush", bus.flush, e_busy);
    chk("redirect_valid", bus.redirect_valid, m_pend);
    chk("redirect_pc", bus.redirect_pc, m_pc);
    chk("stall_dec", bus.stall_dec, e_stall);
    chk("jal_grant", bus.jal_grant, e_grant);
    chk("misalign_trap", bus.misalign_trap, m_trap);
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.br_req = 0; bus.br_target = 0; bus.jal_req = 0; bus.jal_is_jalr = 0;
    bus.jal_rs = 0; bus.jal_target = 0; bus.issue_valid = 0; bus.issue_rd = 0;
    bus.fetch_ready = 0;
  endtask

  initial begin
    int nstall;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    tick();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_pc", bus.redirect_pc, 32'h0);
    reset = 1'b0;
    tick();

    // JAL to 0x100 with fetch ready
    bus.jal_req = 1; bus.jal_target = 32'h100; bus.fetch_ready = 1;
    tick();
    chk("jal_grant_idle", s_grant, 1'b1);
    bus.jal_req = 0;
    chk("jal_pc", bus.redirect_pc, 32'h100);
    chk("jal_rv", bus.redirect_valid, 1'b1);
    chk("jal_flush", bus.flush, 1'b1);
    repeat (3) tick();
    chk("jal_flush_done", bus.flush, 1'b0);
    chk("jal_busy_done", bus.busy, 1'b0);

    // branch beats same-cycle JAL
    bus.br_req = 1; bus.br_target = 32'h200; bus.jal_req = 1; bus.jal_target = 32'h300;
    tick();
    chk("br_beats_jal_grant", s_grant, 1'b0);
    chk("br_beats_jal_pc", bus.redirect_pc, 32'h200);
    bus.br_req = 0; bus.jal_req = 0;
    repeat (4) tick();

    // branch overrides a held JAL redirect
    bus.fetch_ready = 0; bus.jal_req = 1; bus.jal_target = 32'h104;
    tick();
    bus.jal_req = 0;
    tick();
    bus.br_req = 1; bus.br_target = 32'h400;
    tick();
    bus.br_req = 0;
    chk("override_pc", bus.redirect_pc, 32'h400);
    tick();
    chk("override_held", bus.redirect_valid, 1'b1);
    chk("override_flush", bus.flush, 1'b1);
    bus.fetch_ready = 1;
    tick();
    bus.fetch_ready = 0;
    repeat (3) tick();

    // JALR rs hazard against a just-issued rd
    bus.issue_valid = 1; bus.issue_rd = 5;
    tick();
    bus.issue_valid = 0;
    bus.jal_req = 1; bus.jal_is_jalr = 1; bus.jal_rs = 5; bus.jal_target = 32'h600;
    nstall = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_grant) break;
      nstall++;
    end
    chk("jalr_stall_cycles", nstall, SB_DEPTH);
    bus.jal_req = 0; bus.fetch_ready = 1;
    repeat (4) tick();

    // x0 never hazards
    bus.issue_valid = 1; bus.issue_rd = 0;
    tick();
    bus.issue_valid = 0;
    bus.jal_req = 1; bus.jal_is_jalr = 1; bus.jal_rs = 0; bus.jal_target = 32'h700;
    tick();
    chk("jalr_x0_stall", s_stall, 1'b0);
    chk("jalr_x0_grant", s_grant, 1'b1);
    bus.jal_req = 0;
    repeat (4) tick();

    // reset during REDIRECT abandons redirect and clears scoreboard
    bus.fetch_ready = 0;
    bus.issue_valid = 1; bus.issue_rd = 9;
    bus.jal_req = 1; bus.jal_is_jalr = 0; bus.jal_target = 32'h800;
    tick();
    bus.issue_valid = 0; bus.jal_req = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rv", bus.redirect_valid, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_pc", bus.redirect_pc, 32'h0);
    bus.jal_req = 1; bus.jal_is_jalr = 1; bus.jal_rs = 9; bus.jal_target = 32'h900;
    tick();
    chk("rst_sb_clear", s_stall, 1'b0);
    bus.jal_req = 0; bus.fetch_ready = 1;
    repeat (4) tick();

    // misaligned target
    bus.jal_req = 1; bus.jal_is_jalr = 0; bus.jal_target = 32'h102;
    tick();
    bus.jal_req = 0;
`ifdef MISALIGN_TRAP_EN
    chk("misalign_pc", bus.redirect_pc, TRAP_VEC);
    chk("misalign_trap", bus.misalign_trap, 1'b1);
`else
    chk("misalign_pc", bus.redirect_pc, 32'h100);
    chk("misalign_trap", bus.misalign_trap, 1'b0);
`endif
    tick();
    chk("misalign_trap_pulse", bus.misalign_trap, 1'b0);
    repeat (3) tick();

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      reset           = ($urandom_range(0, 49) == 0);
      bus.br_req      = ($urandom_range(0, 9) == 0);
      bus.br_target   = $urandom;
      bus.jal_req     = ($urandom_range(0, 2) == 0);
      bus.jal_is_jalr = $urandom_range(0, 1);
      bus.jal_rs      = 5'($urandom_range(0, 7));
      bus.jal_target  = $urandom;
      bus.issue_valid = $urandom_range(0, 1);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.fetch_ready = $urandom_range(0, 1);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
